// File: rtl/pipe_stall_ctrl_pkg.sv
// pipe_stall_ctrl_pkg
//   Shared widths and FSM state encoding for the data-memory stall controller.
//   DATA_LEN : datapath / address width
//   REG_SIZE : register-index width
//   state_e  : IDLE=0, BUSY=1, ERR=2
package pipe_stall_ctrl_pkg;

    localparam int DATA_LEN = 32;
    localparam int REG_SIZE = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_stall_ctrl_hazard.sv
// hazard_detect
//   Purely combinational load-use compare between the ID/EX load and the
//   IF/ID source operands. x0 never creates a dependency.
//   Ports:
//     idex_memread_i  ID/EX instruction is a load
//     idex_rd_i       ID/EX destination register
//     ifid_rs1_i      IF/ID source 1
//     ifid_rs2_i      IF/ID source 2
//     hz_o            load-use hazard present
module hazard_detect
    import pipe_stall_ctrl_pkg::*;
(
    input  logic                idex_memread_i,
    input  logic [REG_SIZE-1:0] idex_rd_i,
    input  logic [REG_SIZE-1:0] ifid_rs1_i,
    input  logic [REG_SIZE-1:0] ifid_rs2_i,
    output logic                hz_o
);

    assign hz_o = idex_memread_i && (idex_rd_i != '0) &&
                  ((idex_rd_i == ifid_rs1_i) || (idex_rd_i == ifid_rs2_i));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl
//   Sequences the data-memory handshake for the EX/MEM load/store, drives the
//   global Data_Stall_o freeze, and resolves load-use hazards (PC/IF-ID hold
//   plus ID/EX bubble).
//   Optional build macro: STALL_PERF_EN adds stall_cnt_o / acc_cnt_o.
//   Ports:
//     clk_i, rst_i                 clock, synchronous active-high reset
//     MemRead_i, MemWrite_i        EX/MEM access type (both set = store)
//     addr_i, wdata_i              EX/MEM address and store data
//     mem_ack_i, mem_rdata_i       memory completion and load data
//     IDEX_MemRead_i, IDEX_rd_i    ID/EX load and destination
//     IFID_rs1_i, IFID_rs2_i       IF/ID sources
//     mem_req_o, mem_we_o,
//     mem_addr_o, mem_wdata_o      memory request, held stable until ack
//     rdata_o                      load data toward MEM/WB
//     Data_Stall_o                 freeze all pipeline registers and PC
//     PCWrite_o, IFIDWrite_o       0 = hold (load-use)
//     NoOp_o                       1 = ID/EX bubble
//     err_o                        memory timeout, sticky until reset
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                MemRead_i,
    input  logic                MemWrite_i,
    input  logic [DATA_LEN-1:0] addr_i,
    input  logic [DATA_LEN-1:0] wdata_i,
    input  logic                mem_ack_i,
    input  logic [DATA_LEN-1:0] mem_rdata_i,
    input  logic                IDEX_MemRead_i,
    input  logic [REG_SIZE-1:0] IDEX_rd_i,
    input  logic [REG_SIZE-1:0] IFID_rs1_i,
    input  logic [REG_SIZE-1:0] IFID_rs2_i,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_LEN-1:0] mem_addr_o,
    output logic [DATA_LEN-1:0] mem_wdata_o,
    output logic [DATA_LEN-1:0] rdata_o,
    output logic                Data_Stall_o,
    output logic                PCWrite_o,
    output logic                IFIDWrite_o,
    output logic                NoOp_o,
    output logic                err_o
`ifdef STALL_PERF_EN
    ,
    output logic [31:0]         stall_cnt_o,
    output logic [31:0]         acc_cnt_o
`endif
);

    // Counter only needs to reach TIMEOUT-1.
    localparam int               CNT_W   = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    logic [DATA_LEN-1:0] addr_q, addr_d;
    logic [DATA_LEN-1:0] wdata_q, wdata_d;
    logic [DATA_LEN-1:0] rdata_q, rdata_d;
    logic                acc, ack_evt, hz;

    assign acc = MemRead_i | MemWrite_i;

    hazard_detect u_hazard (
        .idex_memread_i (IDEX_MemRead_i),
        .idex_rd_i      (IDEX_rd_i),
        .ifid_rs1_i     (IFID_rs1_i),
        .ifid_rs2_i     (IFID_rs2_i),
        .hz_o           (hz)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        mem_req_o    = 1'b0;
        Data_Stall_o = 1'b0;
        rdata_o      = rdata_q;
        err_o        = 1'b0;
        ack_evt      = 1'b0;
        case (state_q)
            IDLE: begin
                // mem_ack_i is deliberately ignored here.
                Data_Stall_o = acc;
                if (acc) begin
                    we_d    = MemWrite_i;   // read+write collapses to store
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                mem_req_o    = 1'b1;
                Data_Stall_o = !mem_ack_i;
                if (mem_ack_i) begin
                    // Forward in the ack cycle so MEM/WB captures it on the
                    // releasing edge; keep a copy for later cycles.
                    ack_evt = 1'b1;
                    rdata_o = mem_rdata_i;
                    rdata_d = mem_rdata_i;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ERR: begin
                err_o        = 1'b1;
                Data_Stall_o = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory stall dominates the load-use bubble: a frozen ID/EX must not be
    // overwritten with a NOP.
    always_comb begin
        PCWrite_o   = !(Data_Stall_o || hz);
        IFIDWrite_o = !(Data_Stall_o || hz);
        NoOp_o      = hz && !Data_Stall_o;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

`ifdef STALL_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] acc_cnt_q, acc_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, Data_Stall_o};
        acc_cnt_d   = acc_cnt_q + {31'd0, ack_evt};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            acc_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            acc_cnt_q   <= acc_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign acc_cnt_o   = acc_cnt_q;
`else
    logic unused_ack_evt;
    assign unused_ack_evt = ack_evt;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl
//   Scoreboard bench: the driver applies one cycle of stimulus, computes the
//   expected outputs from a transaction-level model and queues them; a
//   monitor on the falling edge pops and compares.
module tb_pipe_stall_ctrl;

    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        MemRead_i = 1'b0, MemWrite_i = 1'b0;
    logic [31:0] addr_i = '0, wdata_i = '0;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic        IDEX_MemRead_i = 1'b0;
    logic [4:0]  IDEX_rd_i = '0, IFID_rs1_i = '0, IFID_rs2_i = '0;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o, rdata_o;
    logic        Data_Stall_o, PCWrite_o, IFIDWrite_o, NoOp_o, err_o;
`ifdef STALL_PERF_EN
    logic [31:0] stall_cnt_o, acc_cnt_o;
`endif

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .addr_i(addr_i), .wdata_i(wdata_i),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .IDEX_MemRead_i(IDEX_MemRead_i), .IDEX_rd_i(IDEX_rd_i),
        .IFID_rs1_i(IFID_rs1_i), .IFID_rs2_i(IFID_rs2_i),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .rdata_o(rdata_o), .Data_Stall_o(Data_Stall_o),
        .PCWrite_o(PCWrite_o), .IFIDWrite_o(IFIDWrite_o),
        .NoOp_o(NoOp_o), .err_o(err_o)
`ifdef STALL_PERF_EN
        , .stall_cnt_o(stall_cnt_o), .acc_cnt_o(acc_cnt_o)
`endif
    );

    typedef struct packed {
        logic        req, we;
        logic [31:0] addr, wdata, rdata;
        logic        stall, pcw, ifw, noop, err;
        logic [31:0] scnt, acnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err = 0;

    // Reference model: one outstanding request, a count of cycles it has
    // waited, a dead flag after a timeout, and the last completed read data.
    bit          m_known = 0;
    bit          m_busy = 0, m_dead = 0;
    int          m_wait = 0;
    logic        m_we = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, m_last = 0;
    logic [31:0] m_scnt = 0, m_acnt = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exv);
        n_checks++;
        if (act !== exv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exv, $time);
        end
    endtask

    task automatic step(input logic r, input logic mr, input logic mw,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic ak, input logic [31:0] rd,
                        input logic imr, input logic [4:0] ird,
                        input logic [4:0] s1, input logic [4:0] s2);
        exp_t e;
        logic acc, hz;
        @(posedge clk); #1;
        rst_i = r; MemRead_i = mr; MemWrite_i = mw; addr_i = a; wdata_i = wd;
        mem_ack_i = ak; mem_rdata_i = rd;
        IDEX_MemRead_i = imr; IDEX_rd_i = ird; IFID_rs1_i = s1; IFID_rs2_i = s2;
        acc = mr | mw;
        hz  = imr && (ird != 0) && (ird == s1 || ird == s2);
        if (m_known) begin
            e.err   = m_dead;
            e.req   = m_busy;
            e.we    = m_we;
            e.addr  = m_addr;
            e.wdata = m_wdata;
            e.stall = m_dead ? 1'b1 : (m_busy ? !ak : acc);
            e.rdata = (m_busy && ak) ? rd : m_last;
            e.pcw   = !e.stall && !hz;
            e.ifw   = !e.stall && !hz;
            e.noop  = !e.stall && hz;
            e.scnt  = m_scnt;
            e.acnt  = m_acnt;
            exp_q.push_back(e);
        end
        if (r) begin
            m_known = 1; m_busy = 0; m_dead = 0; m_wait = 0;
            m_we = 0; m_addr = 0; m_wdata = 0; m_last = 0; m_scnt = 0; m_acnt = 0;
        end else if (m_known) begin
            if (!m_dead) begin
                if (m_busy) begin
                    if (ak) begin
                        m_busy = 0; m_last = rd; m_acnt++;
                    end else if (m_wait == TIMEOUT - 1) begin
                        m_busy = 0; m_dead = 1;
                    end else begin
                        m_wait++;
                    end
                end else if (acc) begin
                    m_busy = 1; m_wait = 0; m_we = mw; m_addr = a; m_wdata = wd;
                end
            end
            m_scnt += {31'd0, e.stall};
        end
    endtask

    task automatic mem(input logic r, input logic mr, input logic mw, input logic [31:0] a,
                       input logic [31:0] wd, input logic ak, input logic [31:0] rd);
        step(r, mr, mw, a, wd, ak, rd, 1'b0, 5'd0, 5'd0, 5'd0);
    endtask

    // Monitor: every cycle the DUT presents a full output vector.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("mem_req",   {31'd0, mem_req_o},    {31'd0, e.req});
                chk("mem_we",    {31'd0, mem_we_o},     {31'd0, e.we});
                chk("mem_addr",  mem_addr_o,            e.addr);
                chk("mem_wdata", mem_wdata_o,           e.wdata);
                chk("rdata",     rdata_o,               e.rdata);
                chk("stall",     {31'd0, Data_Stall_o}, {31'd0, e.stall});
                chk("pcwrite",   {31'd0, PCWrite_o},    {31'd0, e.pcw});
                chk("ifidwrite", {31'd0, IFIDWrite_o},  {31'd0, e.ifw});
                chk("noop",      {31'd0, NoOp_o},       {31'd0, e.noop});
                chk("err",       {31'd0, err_o},        {31'd0, e.err});
`ifdef STALL_PERF_EN
                chk("stall_cnt", stall_cnt_o, e.scnt);
                chk("acc_cnt",   acc_cnt_o,   e.acnt);
`endif
            end
        end
    end

    initial begin
        // Reset (second cycle checks reset values).
        mem(1, 0, 0, 0, 0, 0, 0);
        mem(1, 0, 0, 0, 0, 0, 0);
        mem(0, 0, 0, 0, 0, 1, 32'h5555_5555);          // ack in IDLE ignored
        // Load 0x40 acked on first BUSY cycle.
        mem(0, 1, 0, 32'h40, 0, 0, 0);
        mem(0, 1, 0, 32'h40, 0, 1, 32'hDEAD_BEEF);
        mem(0, 0, 0, 0, 0, 0, 0);
        // Store 0x80/0x1234, ack after several BUSY cycles.
        mem(0, 0, 1, 32'h80, 32'h1234, 0, 0);
        for (int i = 0; i < 4; i++) mem(0, 0, 1, 32'h80, 32'h1234, 0, 0);
        mem(0, 0, 1, 32'h80, 32'h1234, 1, 32'h0BAD_F00D);
        mem(0, 0, 0, 0, 0, 0, 0);
        // Load then back-to-back store.
        mem(0, 1, 0, 32'h100, 0, 0, 0);
        mem(0, 1, 0, 32'h100, 0, 1, 32'h1111_2222);
        mem(0, 1, 1, 32'h104, 32'hAAAA, 0, 0);         // both set -> store
        mem(0, 1, 1, 32'h104, 32'hAAAA, 1, 32'h3333);
        mem(0, 0, 0, 0, 0, 0, 0);
        // Load-use hazard, then rd=0, then hazard under a memory stall.
        step(0, 0, 0, 0, 0, 0, 0, 1, 5'd5, 5'd1, 5'd5);
        step(0, 0, 0, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 5'd2);
        step(0, 1, 0, 32'h8, 0, 0, 0, 1, 5'd7, 5'd7, 5'd2);
        step(0, 1, 0, 32'h8, 0, 1, 32'h77, 1, 5'd7, 5'd7, 5'd2);
        // Ack in the last permitted BUSY cycle wins over timeout.
        mem(0, 1, 0, 32'h200, 0, 0, 0);
        for (int i = 0; i < TIMEOUT - 1; i++) mem(0, 1, 0, 32'h200, 0, 0, 0);
        mem(0, 1, 0, 32'h200, 0, 1, 32'hCAFE_0001);
        mem(0, 0, 0, 0, 0, 0, 0);
        // Timeout into ERR, ack ignored there, then reset.
        mem(0, 0, 1, 32'h300, 32'h99, 0, 0);
        for (int i = 0; i < TIMEOUT; i++) mem(0, 0, 1, 32'h300, 32'h99, 0, 0);
        mem(0, 0, 0, 0, 0, 1, 32'h1);
        mem(0, 0, 0, 0, 0, 0, 0);
        mem(1, 0, 0, 0, 0, 0, 0);
        mem(0, 0, 0, 0, 0, 0, 0);
        // Reset in the second BUSY cycle.
        mem(0, 1, 0, 32'h400, 0, 0, 0);
        mem(0, 1, 0, 32'h400, 0, 0, 0);
        mem(1, 1, 0, 32'h400, 0, 0, 0);
        mem(0, 0, 0, 0, 0, 0, 0);
        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            logic r, mr, mw, ak;
            r  = m_dead ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 199) == 0);
            mr = ($urandom_range(0, 2) == 0);
            mw = ($urandom_range(0, 3) == 0);
            ak = ($urandom_range(0, 3) == 0);
            step(r, mr, mw, $urandom, $urandom, ak, $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
        end
        mem(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
